// File: rtl/glitch_sweep_scheduler.sv
// Glitch campaign sequencer: walks a (delay x width) grid with repeats, power-cycling the
// target, arming the pulse engine and handing each attempt's result to the reporter.
module glitch_sweep_scheduler #(
    parameter int DW             = 16,
    parameter int WW             = 8,
    parameter int RESET_CYCLES   = 16,
    parameter int SETTLE_CYCLES  = 64,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic [DW-1:0] cfg_delay_start_i,
    input  logic [DW-1:0] cfg_delay_end_i,
    input  logic [DW-1:0] cfg_delay_step_i,
    input  logic [WW-1:0] cfg_width_start_i,
    input  logic [WW-1:0] cfg_width_end_i,
    input  logic [WW-1:0] cfg_width_step_i,
    input  logic [7:0]    cfg_repeat_i,
    output logic          eng_arm_o,
    output logic [DW-1:0] eng_delay_o,
    output logic [WW-1:0] eng_width_o,
    input  logic          eng_done_i,
    output logic          target_reset_o,
    output logic          res_valid_o,
    input  logic          res_ready_i,
    output logic [DW-1:0] res_delay_o,
    output logic [WW-1:0] res_width_o,
    output logic          res_timeout_o,
    output logic          busy_o,
    output logic          sweep_done_o
);

    localparam int MAX_RS = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
    localparam int MAXC   = (MAX_RS > TIMEOUT_CYCLES) ? MAX_RS : TIMEOUT_CYCLES;
    localparam int CW     = $clog2(MAXC + 1);
    localparam logic [CW-1:0] R_LAST = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] S_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RESET, S_SETTLE, S_ARM, S_WAIT, S_REPORT, S_NEXT
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    rep_q, rep_max_q;
    logic [DW-1:0] delay_q, d_end_q, d_step_q;
    logic [WW-1:0] width_q, w_start_q, w_end_q, w_step_q;

    logic          eng_arm_q, target_reset_q, res_valid_q, res_timeout_q, sweep_done_q;
    logic [DW-1:0] eng_delay_q, res_delay_q;
    logic [WW-1:0] eng_width_q, res_width_q;

    logic [DW:0]   d_sum;
    logic [WW:0]   w_sum;
    logic          d_exh, w_exh, rep_more, last_point;
    logic [DW-1:0] delay_d;
    logic [WW-1:0] width_d;
    logic [7:0]    rep_d;

    // Next grid point: sums are one bit wider so a carry counts as running off the axis.
    always_comb begin
        d_sum      = {1'b0, delay_q} + {1'b0, d_step_q};
        w_sum      = {1'b0, width_q} + {1'b0, w_step_q};
        d_exh      = (d_step_q == '0) || d_sum[DW] || (d_sum[DW-1:0] > d_end_q);
        w_exh      = (w_step_q == '0) || w_sum[WW] || (w_sum[WW-1:0] > w_end_q);
        rep_more   = ({1'b0, rep_q} + 9'd1) < {1'b0, rep_max_q};
        last_point = !rep_more && w_exh && d_exh;
        rep_d      = rep_q;
        width_d    = width_q;
        delay_d    = delay_q;
        if (rep_more) begin
            rep_d = rep_q + 8'd1;
        end else begin
            rep_d = '0;
            if (!w_exh) begin
                width_d = w_sum[WW-1:0];
            end else begin
                width_d = w_start_q;
                if (!d_exh) delay_d = d_sum[DW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            rep_q          <= '0;
            rep_max_q      <= '0;
            delay_q        <= '0;
            d_end_q        <= '0;
            d_step_q       <= '0;
            width_q        <= '0;
            w_start_q      <= '0;
            w_end_q        <= '0;
            w_step_q       <= '0;
            eng_arm_q      <= 1'b0;
            eng_delay_q    <= '0;
            eng_width_q    <= '0;
            target_reset_q <= 1'b0;
            res_valid_q    <= 1'b0;
            res_delay_q    <= '0;
            res_width_q    <= '0;
            res_timeout_q  <= 1'b0;
            sweep_done_q   <= 1'b0;
        end else begin
            eng_arm_q    <= 1'b0;
            sweep_done_q <= 1'b0;
            if (abort_i) begin
                state_q        <= S_IDLE;
                cnt_q          <= '0;
                rep_q          <= '0;
                eng_delay_q    <= '0;
                eng_width_q    <= '0;
                target_reset_q <= 1'b0;
                res_valid_q    <= 1'b0;
                res_delay_q    <= '0;
                res_width_q    <= '0;
                res_timeout_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_i) begin
                            delay_q        <= cfg_delay_start_i;
                            d_end_q        <= cfg_delay_end_i;
                            d_step_q       <= cfg_delay_step_i;
                            width_q        <= cfg_width_start_i;
                            w_start_q      <= cfg_width_start_i;
                            w_end_q        <= cfg_width_end_i;
                            w_step_q       <= cfg_width_step_i;
                            rep_max_q      <= (cfg_repeat_i == 8'd0) ? 8'd1 : cfg_repeat_i;
                            rep_q          <= '0;
                            cnt_q          <= '0;
                            eng_delay_q    <= cfg_delay_start_i;
                            eng_width_q    <= cfg_width_start_i;
                            target_reset_q <= 1'b1;
                            state_q        <= S_RESET;
                        end
                    end
                    S_RESET: begin
                        if (cnt_q == R_LAST) begin
                            cnt_q          <= '0;
                            target_reset_q <= 1'b0;
                            state_q        <= S_SETTLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_SETTLE: begin
                        if (cnt_q == S_LAST) begin
                            cnt_q     <= '0;
                            eng_arm_q <= 1'b1;
                            state_q   <= S_ARM;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_ARM: begin
                        cnt_q   <= '0;
                        state_q <= S_WAIT;
                    end
                    // A done arriving in the expiry cycle still counts as a real completion.
                    S_WAIT: begin
                        if (eng_done_i || (cnt_q == T_LAST)) begin
                            cnt_q         <= '0;
                            res_valid_q   <= 1'b1;
                            res_delay_q   <= delay_q;
                            res_width_q   <= width_q;
                            res_timeout_q <= !eng_done_i;
                            state_q       <= S_REPORT;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_REPORT: begin
                        if (res_ready_i) begin
                            res_valid_q  <= 1'b0;
                            sweep_done_q <= last_point;
                            state_q      <= S_NEXT;
                        end
                    end
                    S_NEXT: begin
                        cnt_q <= '0;
                        rep_q <= rep_d;
                        if (last_point) begin
                            eng_delay_q <= '0;
                            eng_width_q <= '0;
                            state_q     <= S_IDLE;
                        end else begin
                            delay_q        <= delay_d;
                            width_q        <= width_d;
                            eng_delay_q    <= delay_d;
                            eng_width_q    <= width_d;
                            target_reset_q <= 1'b1;
                            state_q        <= S_RESET;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign eng_arm_o      = eng_arm_q;
    assign eng_delay_o    = eng_delay_q;
    assign eng_width_o    = eng_width_q;
    assign target_reset_o = target_reset_q;
    assign res_valid_o    = res_valid_q;
    assign res_delay_o    = res_delay_q;
    assign res_width_o    = res_width_q;
    assign res_timeout_o  = res_timeout_q;
    assign busy_o         = (state_q != S_IDLE);
    assign sweep_done_o   = sweep_done_q;

endmodule

// File: tb/tb_glitch_sweep_scheduler.sv
// Bench for glitch_sweep_scheduler: a small engine model answers arms, and every expected
// result is queued when a sweep starts and popped when the reporter handshake completes.
module tb_glitch_sweep_scheduler;

    localparam int DW = 16;
    localparam int WW = 8;
    localparam int RC = 4;
    localparam int SC = 8;
    localparam int TC = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i, abort_i, res_ready_i;
    logic [DW-1:0] cfg_delay_start_i, cfg_delay_end_i, cfg_delay_step_i;
    logic [WW-1:0] cfg_width_start_i, cfg_width_end_i, cfg_width_step_i;
    logic [7:0]    cfg_repeat_i;
    logic          eng_arm_o, target_reset_o, res_valid_o, res_timeout_o, busy_o, sweep_done_o;
    logic [DW-1:0] eng_delay_o, res_delay_o;
    logic [WW-1:0] eng_width_o, res_width_o;
    logic          modelDone, manualDone;
    wire logic     eng_done_i = modelDone | manualDone;

    typedef struct {
        int d;
        int w;
        bit to;
    } exp_t;

    exp_t sbQueue[$];
    int   checkCount = 0;
    int   errorCount = 0;
    int   donePulses = 0;
    int   armCount   = 0;
    bit   echoEn     = 1'b0;
    int   echoDelay  = 5;

    always #5 clk = ~clk;

    glitch_sweep_scheduler #(
        .DW(DW), .WW(WW), .RESET_CYCLES(RC), .SETTLE_CYCLES(SC), .TIMEOUT_CYCLES(TC)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
        .cfg_delay_start_i(cfg_delay_start_i), .cfg_delay_end_i(cfg_delay_end_i),
        .cfg_delay_step_i(cfg_delay_step_i), .cfg_width_start_i(cfg_width_start_i),
        .cfg_width_end_i(cfg_width_end_i), .cfg_width_step_i(cfg_width_step_i),
        .cfg_repeat_i(cfg_repeat_i), .eng_arm_o(eng_arm_o), .eng_delay_o(eng_delay_o),
        .eng_width_o(eng_width_o), .eng_done_i(eng_done_i), .target_reset_o(target_reset_o),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_delay_o(res_delay_o),
        .res_width_o(res_width_o), .res_timeout_o(res_timeout_o), .busy_o(busy_o),
        .sweep_done_o(sweep_done_o)
    );

    // Engine model: pulses done echoDelay cycles after the cycle in which arm is seen.
    always begin
        @(negedge clk);
        if (echoEn && eng_arm_o) begin
            repeat (echoDelay) @(posedge clk);
            #1 modelDone = 1'b1;
            @(posedge clk);
            #1 modelDone = 1'b0;
        end
    end

    // Reporter side: every completed handshake is checked against the head of the queue.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (sweep_done_o) donePulses++;
            if (eng_arm_o) armCount++;
            if (res_valid_o && res_ready_i) begin
                checkCount++;
                if (sbQueue.size() == 0) begin
                    errorCount++;
                    $display("[TB] FAIL unexpected_result: got d=%0h w=%0h to=%0b, required no result",
                             res_delay_o, res_width_o, res_timeout_o);
                end else begin
                    e = sbQueue.pop_front();
                    if (res_delay_o !== 16'(e.d) || res_width_o !== 8'(e.w) || res_timeout_o !== e.to) begin
                        errorCount++;
                        $display("[TB] FAIL result: got d=%0h w=%0h to=%0b, required d=%0h w=%0h to=%0b",
                                 res_delay_o, res_width_o, res_timeout_o, e.d, e.w, e.to);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int ds, de, dst, ws, we, wst, rep);
        cfg_delay_start_i = 16'(ds);
        cfg_delay_end_i   = 16'(de);
        cfg_delay_step_i  = 16'(dst);
        cfg_width_start_i = 8'(ws);
        cfg_width_end_i   = 8'(we);
        cfg_width_step_i  = 8'(wst);
        cfg_repeat_i      = 8'(rep);
    endtask

    // Reference ordering: repeats innermost, then width, then delay.
    task automatic pushGrid(input int ds, de, dst, ws, we, wst, rep, input bit to);
        int  d, w, n, r;
        bit  wMore, dMore;
        r = (rep == 0) ? 1 : rep;
        d = ds;
        do begin
            w = ws;
            do begin
                for (int k = 0; k < r; k++) sbQueue.push_back('{d, w, to});
                n     = w + wst;
                wMore = (wst != 0) && (n <= we) && (n <= 255);
                w     = n;
            end while (wMore);
            n     = d + dst;
            dMore = (dst != 0) && (n <= de) && (n <= 65535);
            d     = n;
        end while (dMore);
    endtask

    task automatic startSweep;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic waitIdle(input int budget, input string name);
        int n = 0;
        @(negedge clk);
        while (busy_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkCount++;
        if (busy_o !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL %s_finish: busy_o=%b after %0d cycles, required 0", name, busy_o, budget);
        end
    endtask

    task automatic waitArm(input int budget, output bit seen);
        int n = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge clk);
            if (eng_arm_o) seen = 1'b1;
            n++;
        end
        checkCount++;
        if (!seen) begin
            errorCount++;
            $display("[TB] FAIL arm_wait: arm not seen in %0d cycles, required arm", budget);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checkCount++;
        if ({eng_arm_o, target_reset_o, res_valid_o, res_timeout_o, busy_o, sweep_done_o} !== 6'b0) begin
            errorCount++;
            $display("[TB] FAIL reset_flags: got %b, required 000000",
                     {eng_arm_o, target_reset_o, res_valid_o, res_timeout_o, busy_o, sweep_done_o});
        end
        checkCount++;
        if ({eng_delay_o, eng_width_o, res_delay_o, res_width_o} !== '0) begin
            errorCount++;
            $display("[TB] FAIL reset_data: got %h %h %h %h, required 0",
                     eng_delay_o, eng_width_o, res_delay_o, res_width_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_sweep;
        int d0 = donePulses;
        echoEn = 1'b1;
        echoDelay = 5;
        applyStimulus(10, 20, 10, 3, 4, 1, 1);
        pushGrid(10, 20, 10, 3, 4, 1, 1, 1'b0);
        startSweep();
        applyStimulus(99, 999, 1, 9, 99, 1, 5);
        waitIdle(1000, "basic");
        checkCount++;
        if (sbQueue.size() != 0) begin
            errorCount++;
            $display("[TB] FAIL basic_results: %0d pending, required 0", sbQueue.size());
        end
        checkCount++;
        if (donePulses - d0 != 1) begin
            errorCount++;
            $display("[TB] FAIL basic_done: got %0d pulses, required 1", donePulses - d0);
        end
    endtask

    task automatic test_timing;
        bit bad = 1'b0;
        echoEn = 1'b1;
        echoDelay = 5;
        applyStimulus(100, 100, 1, 7, 7, 1, 1);
        pushGrid(100, 100, 1, 7, 7, 1, 1, 1'b0);
        startSweep();
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            checkCount++;
            if (target_reset_o !== (k <= RC) || eng_arm_o !== (k == RC + SC + 1)) begin
                errorCount++;
                $display("[TB] FAIL timing_cycle%0d: tr=%b arm=%b, required tr=%b arm=%b",
                         k, target_reset_o, eng_arm_o, (k <= RC), (k == RC + SC + 1));
            end
            if (k == 1 && (eng_delay_o !== 16'd100 || eng_width_o !== 8'd7)) bad = 1'b1;
        end
        checkCount++;
        if (bad) begin
            errorCount++;
            $display("[TB] FAIL timing_point: eng point not 100/7 at RESET entry, required 100/7");
        end
        waitIdle(500, "timing");
    endtask

    task automatic test_axis_boundaries;
        int a0 = armCount;
        echoEn = 1'b1;
        echoDelay = 5;
        applyStimulus('hFFF0, 'hFFFF, 'h20, 1, 1, 1, 1);
        pushGrid('hFFF0, 'hFFFF, 'h20, 1, 1, 1, 1, 1'b0);
        startSweep();
        waitIdle(500, "saturate");
        checkCount++;
        if (armCount - a0 != 1) begin
            errorCount++;
            $display("[TB] FAIL saturate_attempts: got %0d arms, required 1", armCount - a0);
        end
        applyStimulus(7, 5, 1, 2, 9, 0, 3);
        pushGrid(7, 5, 1, 2, 9, 0, 3, 1'b0);
        startSweep();
        waitIdle(1000, "repeat3");
        applyStimulus(4, 4, 0, 250, 255, 5, 0);
        pushGrid(4, 4, 0, 250, 255, 5, 0, 1'b0);
        startSweep();
        waitIdle(1000, "repeat0");
        checkCount++;
        if (sbQueue.size() != 0) begin
            errorCount++;
            $display("[TB] FAIL axis_results: %0d pending, required 0", sbQueue.size());
        end
    endtask

    task automatic test_timeout;
        bit seen;
        int n = 0;
        echoEn = 1'b0;
        applyStimulus(33, 33, 1, 44, 44, 1, 1);
        pushGrid(33, 33, 1, 44, 44, 1, 1, 1'b1);
        startSweep();
        waitArm(100, seen);
        while (!res_valid_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkCount++;
        if (n != TC + 1) begin
            errorCount++;
            $display("[TB] FAIL timeout_latency: result %0d cycles after arm, required %0d", n, TC + 1);
        end
        checkCount++;
        if (res_timeout_o !== 1'b1) begin
            errorCount++;
            $display("[TB] FAIL timeout_flag: got %b, required 1", res_timeout_o);
        end
        waitIdle(100, "timeout");
        echoEn = 1'b1;
        echoDelay = TC;
        applyStimulus(34, 34, 1, 45, 45, 1, 1);
        pushGrid(34, 34, 1, 45, 45, 1, 1, 1'b0);
        startSweep();
        waitIdle(500, "done_at_expiry");
    endtask

    task automatic test_backpressure;
        bit          seen;
        int          n = 0;
        int          d0 = donePulses;
        logic [DW-1:0] hd;
        logic [WW-1:0] hw;
        logic          ht;
        echoEn = 1'b1;
        echoDelay = 5;
        res_ready_i = 1'b0;
        applyStimulus(50, 50, 1, 1, 2, 1, 1);
        pushGrid(50, 50, 1, 1, 2, 1, 1, 1'b0);
        startSweep();
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            seen = res_valid_o;
            n++;
        end
        hd = res_delay_o;
        hw = res_width_o;
        ht = res_timeout_o;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            checkCount++;
            if (res_valid_o !== 1'b1 || res_delay_o !== hd || res_width_o !== hw || res_timeout_o !== ht ||
                target_reset_o !== 1'b0 || eng_arm_o !== 1'b0) begin
                errorCount++;
                $display("[TB] FAIL hold_cycle%0d: v=%b d=%h w=%h tr=%b arm=%b, required v=1 d=%h w=%h tr=0 arm=0",
                         k, res_valid_o, res_delay_o, res_width_o, target_reset_o, eng_arm_o, hd, hw);
            end
        end
        tick();
        res_ready_i = 1'b1;
        waitIdle(500, "backpressure");
        checkCount++;
        if (sbQueue.size() != 0 || donePulses - d0 != 1) begin
            errorCount++;
            $display("[TB] FAIL backpressure_end: pending=%0d pulses=%0d, required 0 and 1",
                     sbQueue.size(), donePulses - d0);
        end
    endtask

    task automatic test_abort;
        bit seen;
        bit leak = 1'b0;
        int d0 = donePulses;
        echoEn = 1'b0;
        applyStimulus(60, 61, 1, 5, 5, 1, 1);
        startSweep();
        waitArm(100, seen);
        tick();
        abort_i = 1'b1;
        manualDone = 1'b1;
        tick();
        abort_i = 1'b0;
        manualDone = 1'b0;
        @(negedge clk);
        checkCount++;
        if ({busy_o, res_valid_o, target_reset_o, eng_arm_o, res_timeout_o} !== 5'b0 ||
            eng_delay_o !== '0 || eng_width_o !== '0) begin
            errorCount++;
            $display("[TB] FAIL abort_outputs: busy=%b v=%b d=%h w=%h, required all 0",
                     busy_o, res_valid_o, eng_delay_o, eng_width_o);
        end
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (busy_o || res_valid_o) leak = 1'b1;
        end
        checkCount++;
        if (leak || donePulses != d0) begin
            errorCount++;
            $display("[TB] FAIL abort_quiet: activity=%b pulses=%0d, required 0 and 0", leak, donePulses - d0);
        end
        tick();
        abort_i = 1'b1;
        start_i = 1'b1;
        tick();
        abort_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        checkCount++;
        if (busy_o !== 1'b0) begin
            errorCount++;
            $display("[TB] FAIL abort_beats_start: busy_o=%b, required 0", busy_o);
        end
        echoEn = 1'b1;
        echoDelay = 5;
        pushGrid(60, 61, 1, 5, 5, 1, 1, 1'b0);
        startSweep();
        waitIdle(1000, "after_abort");
        checkCount++;
        if (sbQueue.size() != 0 || donePulses - d0 != 1) begin
            errorCount++;
            $display("[TB] FAIL after_abort_sweep: pending=%0d pulses=%0d, required 0 and 1",
                     sbQueue.size(), donePulses - d0);
        end
    endtask

    initial begin
        rst = 1'b1;
        start_i = 1'b0;
        abort_i = 1'b0;
        res_ready_i = 1'b1;
        modelDone = 1'b0;
        manualDone = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_basic_sweep();
        test_timing();
        test_axis_boundaries();
        test_timeout();
        test_backpressure();
        test_abort();
        repeat (5) tick();
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
